int_div: RTL
============

// Module: int_div
// PURPOSE
//   Multi-cycle 32-bit integer divider for the ALU, the inverse of the shift-add multiplier.
//   Implements RISC-V M-extension DIV/DIVU/REM/REMU with spec-mandated div-by-zero and overflow results.
//   Radix-2 restoring algorithm, one quotient bit per cycle; sits beside the multiplier under the ALU.
// PARAMETERS
//   XLEN   32   operand/result width; count register is $clog2(XLEN) bits
// PORTS
//   i_clk     in   1     clock, rising edge
//   i_rst     in   1     reset, synchronous, active-high
//   i_valid   in   1     start request; operands/op sampled on the same edge
//   i_op      in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_a       in   XLEN  dividend
//   i_b       in   XLEN  divisor
//   o_busy    out  1     high while iterating; i_valid ignored when high
//   o_valid   out  1     one-cycle pulse, o_result valid
//   o_result  out  XLEN  quotient or remainder per latched op; held until next o_valid
// BEHAVIOUR
//   Reset: state IDLE, o_busy=0, o_valid=0, o_result=0, count=0, internal regs cleared.
//   FSM: IDLE -(i_valid)-> CALC; CALC -(count==XLEN-1)-> DONE; DONE -(i_valid)-> CALC, else -> IDLE.
//   Accept: i_valid sampled high in IDLE or DONE -> latch op, sign flags, |a|, |b| (signed ops)
//     or raw a, b (unsigned ops); clear remainder accumulator; count=0.
//   CALC: each cycle rem' = {rem[XLEN-2:0], dvd[XLEN-1]}; if rem' >= dvs then rem' -= dvs, q bit=1;
//     dividend shifts left, q shifts in LSB; count++. Exactly XLEN CALC cycles.
//   Subtractor is XLEN+1 bits wide; borrow-out = 0 means "fits".
//   Latency: accept edge = cycle 0; CALC cycles 1..XLEN; o_valid high in cycle XLEN+1. Fixed for all ops.
//   Sign fix (signed ops only): quotient negated iff sign(a)^sign(b); remainder takes sign of a.
//   Divisor zero (any op): quotient = all ones, remainder = a (unmodified). Overrides sign fix.
//   Overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
//   Special cases still take the full fixed latency (detected at accept, applied at DONE).
//   o_busy = (state==CALC). o_valid = 1 only in the DONE cycle.
//   i_valid while busy: ignored, no queueing. i_valid in DONE: new op accepted, o_valid still pulses for old.
//   i_rst mid-operation: abort on that edge, no o_valid pulse, all regs to reset values.
//   Operand changes after accept have no effect on the running operation.
// STRUCTURE
//   Package alu_pkg: op encodings DIV_OP_DIV/DIVU/REM/REMU, FSM state enum {IDLE,CALC,DONE},
//     XLEN default constant.
//   Sub-module int_div_step: combinational one-bit restoring step
//     (in: rem, dvd_msb, dvs; out: rem_next, q_bit). Top holds FSM, counters, sign/special handling.
// TESTING
//   DIV  a=100,        b=7          -> o_result=14 (0x0000000E), o_valid at cycle 33
//   REM  a=-100,       b=7          -> o_result=-2 (0xFFFFFFFE); DIV same operands -> -14 (0xFFFFFFF2)
//   DIVU a=0xFFFFFFFF, b=2          -> 0x7FFFFFFF; REMU same operands -> 1
//   DIV  a=5, b=0 -> 0xFFFFFFFF; REM a=5, b=0 -> 5; DIVU a=0x80000000, b=0 -> 0xFFFFFFFF
//   DIV  a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM same operands -> 0
//   Control: i_valid pulsed again in cycle 10 is ignored.
//   i_rst in cycle 10 -> no o_valid; fresh DIV 9/3 then returns 3.
//   i_valid in DONE cycle -> back-to-back result 33 cycles later.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider op encodings, divider FSM state codes and default word width.
package alu_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/int_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, subtract the divisor if it fits.
module int_div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_dvd_msb,
  input  logic [XLEN-1:0] i_dvs,
  output logic [XLEN-1:0] o_rem_next,
  output logic            o_q_bit
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;
  logic          w_borrow;
  logic          w_unused;

  assign w_shift = {i_rem, i_dvd_msb};
  // No borrow out of the XLEN+1 bit subtract means the divisor fits.
  assign {w_borrow, w_diff} = {1'b0, w_shift} - {2'b00, i_dvs};
  assign o_q_bit    = ~w_borrow;
  assign o_rem_next = w_borrow ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];

  // Top bits are always zero in the selected result; the remainder stays below the divisor.
  assign w_unused = ^{w_shift[XLEN], w_diff[XLEN]};

endmodule

// File: rtl/int_div.sv
// Multi-cycle RISC-V DIV/DIVU/REM/REMU divider, one quotient bit per cycle, fixed latency.
module int_div
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int unsigned CW = $clog2(XLEN);

  logic [1:0]      r_state;
  logic [CW-1:0]   r_count;
  logic [1:0]      r_op;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_div_zero;
  logic            r_ovf;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_dvd;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_result;

  logic            w_signed;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic [XLEN-1:0] w_rem_next;
  logic            w_q_bit;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;
  logic [XLEN-1:0] w_final;

  assign w_signed = ~i_op[0];
  assign w_abs_a  = i_a[XLEN-1] ? -i_a : i_a;
  assign w_abs_b  = i_b[XLEN-1] ? -i_b : i_b;

  int_div_step #(
    .XLEN(XLEN)
  ) u_step (
    .i_rem     (r_rem),
    .i_dvd_msb (r_dvd[XLEN-1]),
    .i_dvs     (r_dvs),
    .o_rem_next(w_rem_next),
    .o_q_bit   (w_q_bit)
  );

  // Quotient bits shift into the vacated dividend LSBs; this is the full quotient on the last step.
  assign w_quo   = {r_dvd[XLEN-2:0], w_q_bit};
  assign w_q_fix = r_neg_q ? -w_quo : w_quo;
  assign w_r_fix = r_neg_r ? -w_rem_next : w_rem_next;

  always_comb begin
    w_final = r_op[1] ? w_r_fix : w_q_fix;
    if (r_div_zero) begin
      w_final = r_op[1] ? r_a : '1;
    end else if (r_ovf) begin
      w_final = r_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_op       <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_ovf      <= 1'b0;
      r_a        <= '0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_rem      <= '0;
      r_result   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_valid) begin
            r_state    <= ST_CALC;
            r_count    <= '0;
            r_op       <= i_op;
            r_neg_q    <= w_signed & (i_a[XLEN-1] ^ i_b[XLEN-1]);
            r_neg_r    <= w_signed & i_a[XLEN-1];
            r_div_zero <= (i_b == '0);
            r_ovf      <= w_signed & (i_a == {1'b1, {(XLEN-1){1'b0}}}) & (i_b == '1);
            r_a        <= i_a;
            r_dvd      <= w_signed ? w_abs_a : i_a;
            r_dvs      <= w_signed ? w_abs_b : i_b;
            r_rem      <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          r_rem   <= w_rem_next;
          r_dvd   <= w_quo;
          r_count <= r_count + CW'(1);
          if (r_count == CW'(XLEN - 1)) begin
            r_state  <= ST_DONE;
            r_result <= w_final;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy   = (r_state == ST_CALC);
  assign o_valid  = (r_state == ST_DONE);
  assign o_result = r_result;

endmodule
